// File: rtl/warp_imem_responder.sv
// Instruction-memory responder: one fetch in flight, fixed read latency, response mirrored into the warp FIFO.
// Optional `WARP_IMEM_BOUNDS_CHECK_EN: indices >= DEPTH return an error instead of wrapping onto the store.
module warp_imem_responder #(
  parameter int          DEPTH        = 256,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_req,
  input  logic [31:0]              mem_addr,
  output logic                     mem_ready,
  output logic                     mem_valid,
  output logic [31:0]              mem_rdata,
  output logic                     mem_err,
  output logic                     fifo_push,
  output logic [31:0]              fifo_wdata,
  input  logic                     fifo_full,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_wdata,
  output logic [15:0]              resp_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  state_t      state;
  logic [3:0]  lat_cnt;
  resp_t       resp_q;
  logic [31:0] store [DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          misalign, oob, acc_err;

  assign off      = mem_addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign misalign = |mem_addr[1:0];

`ifdef WARP_IMEM_BOUNDS_CHECK_EN
  assign oob = |off[31:AW+2];
  logic [1:0] unused_addr_bits;
  assign unused_addr_bits = off[1:0];
`else
  // Without bounds checking the upper index bits are dropped so fetches wrap onto the store.
  assign oob = 1'b0;
  logic [31-AW:0] unused_addr_bits;
  assign unused_addr_bits = {off[31:AW+2], off[1:0]};
`endif

  assign acc_err    = misalign | oob;
  assign mem_ready  = (state == IDLE);
  assign mem_valid  = (state == RESP) && !fifo_full;
  assign mem_rdata  = resp_q.data;
  assign mem_err    = resp_q.err;
  assign fifo_push  = mem_valid;
  assign fifo_wdata = resp_q.data;

  // Store is intentionally not reset; nonblocking write gives old-data on a same-edge read.
  always_ff @(posedge clk) begin
    if (prog_we) store[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      resp_q     <= '0;
      resp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            resp_q.err  <= acc_err;
            resp_q.data <= acc_err ? 32'h0 : store[idx];
            lat_cnt     <= 4'(READ_LATENCY - 1);
            // The accept edge counts as the first latency cycle, so READ spans READ_LATENCY-1 cycles.
            state       <= (READ_LATENCY == 1) ? RESP : READ;
          end
        end
        READ: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (!fifo_full) begin
            resp_count <= resp_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_warp_imem_responder.sv
// Scoreboard bench for warp_imem_responder: stimulus pushes expected responses, a monitor pops and checks them.
module tb_warp_imem_responder;
  localparam int DEPTH = 256;
  localparam int RL    = 2;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic          mem_ready, mem_valid, mem_err, fifo_push;
  logic [31:0]   mem_rdata, fifo_wdata;
  logic          fifo_full = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_wdata = '0;
  logic [15:0]   resp_count;

  warp_imem_responder #(.DEPTH(DEPTH), .READ_LATENCY(RL), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .fifo_push(fifo_push), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata), .resp_count(resp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && mem_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'(mem_valid), 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rdata", mem_rdata, e.data);
        check("err", 32'(mem_err), 32'(e.err));
        check("fifo_push", 32'(fifo_push), 32'h1);
        check("fifo_wdata", fifo_wdata, e.data);
        check("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic prog(input int idx, input logic [31:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = AW'(idx); prog_wdata = data;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // Waits for mem_ready, presents the request for the accepting edge, optionally with a same-cycle write.
  task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic err,
                       input int stall, input bit push, input bit keep,
                       input bit wr, input int wr_idx, input logic [31:0] wr_data,
                       output int acc_cyc);
    int n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!mem_ready && n < 40) begin @(negedge clk); n++; end
    if (!mem_ready) check("ready_timeout", 32'(mem_ready), 32'h1);
    mem_req = 1'b1; mem_addr = addr;
    if (wr) begin prog_we = 1'b1; prog_addr = AW'(wr_idx); prog_wdata = wr_data; end
    acc_cyc = cyc;
    if (push) begin
      e.data = data; e.err = err; e.due = cyc + RL + stall;
      q.push_back(e);
    end
    @(posedge clk); #1;
    prog_we = 1'b0;
    if (!keep) mem_req = 1'b0;
  endtask

  task automatic drain(input logic [15:0] exp_count, input string name);
    int n = 0;
    while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    if (q.size() != 0) check({name, "_drain_timeout"}, 32'(q.size()), 32'h0);
    @(negedge clk);
    check({name, "_resp_count"}, 32'(resp_count), 32'(exp_count));
    check({name, "_ready_after"}, 32'(mem_ready), 32'h1);
  endtask

  initial begin
    int a, prev;
    logic [31:0] w0_exp;
    logic        w0_err;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'h1);
    check("rst_valid", 32'(mem_valid), 32'h0);
    check("rst_push", 32'(fifo_push), 32'h0);
    check("rst_err", 32'(mem_err), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_wdata", fifo_wdata, 32'h0);
    check("rst_count", 32'(resp_count), 32'h0);
    rst_n = 1'b1;

    prog(5, 32'hDEAD_BEEF);
    prog(0, 32'hCAFE_0000);
    prog(1, 32'h0000_1001);
    prog(2, 32'h0000_1111);
    prog(3, 32'h0000_3003);

    // Basic fetch of word 5
    issue(32'h14, 32'hDEAD_BEEF, 1'b0, 0, 1, 0, 0, 0, 0, a);
    drain(16'd1, "basic");

    // Back-pressure: fifo_full covers the READ cycle plus three RESP cycles
    issue(32'h4, 32'h0000_1001, 1'b0, 3, 1, 0, 0, 0, 0, a);
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready_low", 32'(mem_ready), 32'h0);
      check("bp_no_valid", 32'(mem_valid), 32'h0);
      check("bp_data_held", mem_rdata, 32'h0000_1001);
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    drain(16'd2, "bp");

    // Streaming with mem_req held high: one acceptance every RL+1 cycles
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wv [4];
      wv[0] = 32'hCAFE_0000; wv[1] = 32'h0000_1001; wv[2] = 32'h0000_1111; wv[3] = 32'h0000_3003;
      issue(32'(4 * i), wv[i], 1'b0, 0, 1, 1, 0, 0, 0, a);
      if (prev >= 0) check("stream_spacing", 32'(a - prev), 32'(RL + 1));
      prev = a;
    end
    mem_req = 1'b0;
    drain(16'd6, "stream");

    // Collision: write word 2 on the accepting edge returns the old word
    issue(32'h8, 32'h0000_1111, 1'b0, 0, 1, 0, 1, 2, 32'h0000_2222, a);
    drain(16'd7, "coll_old");
    issue(32'h8, 32'h0000_2222, 1'b0, 0, 1, 0, 0, 0, 0, a);
    drain(16'd8, "coll_new");

    // Errors: misaligned, then 4*DEPTH
    issue(32'h6, 32'h0, 1'b1, 0, 1, 0, 0, 0, 0, a);
    drain(16'd9, "misalign");
`ifdef WARP_IMEM_BOUNDS_CHECK_EN
    w0_exp = 32'h0; w0_err = 1'b1;
`else
    w0_exp = 32'hCAFE_0000; w0_err = 1'b0;
`endif
    issue(32'(4 * DEPTH), w0_exp, w0_err, 0, 1, 0, 0, 0, 0, a);
    drain(16'd10, "range");

    // Reset in READ: the in-flight request is dropped and the count clears
    issue(32'h14, 32'h0, 1'b0, 0, 0, 0, 0, 0, 0, a);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_ready", 32'(mem_ready), 32'h1);
    check("rst_mid_count", 32'(resp_count), 32'h0);
    check("rst_mid_valid", 32'(mem_valid), 32'h0);

    // Responder still works after the mid-flight reset
    issue(32'h14, 32'hDEAD_BEEF, 1'b0, 0, 1, 0, 0, 0, 0, a);
    drain(16'd1, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
